icache_assoc: RTL and testbench

ICACHE_ASSOC -- requirements
Module: icache_assoc

---
 rtl/icache_assoc.sv | 146 ++++++++++++++
 tb/tb_icache_assoc.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/icache_assoc.sv
// Set-associative instruction cache (1 or 2 ways) with a nibble-serial line fill.
// Each line is filled one 4-bit nibble at a time, and the combinational hit path serves fetches from the other ways during a fill.
module icache_assoc #(
   parameter int LINE_LENGTH = 4,
   parameter int NSETS       = 4,
   parameter int NWAYS       = 2,
   parameter int RV          = 16,
   parameter int PA          = 22
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [PA-1:1]                   paddr,
   input  logic [3:0]                      dread,
   input  logic                            wstrobe_d,
   input  logic                            flush_all,
   output logic                            hit,
   output logic                            pull,
   output logic [PA-1:$clog2(LINE_LENGTH)] tag,
   output logic [RV-1:0]                   rdata
);

   // state  | meaning
   // S_IDLE | serve fetches; a miss with a strobe starts a fill
   // S_FILL | collecting nibbles of the latched line into the latched way

   localparam int OFFW  = $clog2(LINE_LENGTH);
   localparam int IDXW  = $clog2(NSETS);
   localparam int TAGW  = PA - OFFW - IDXW;
   localparam int LAW   = PA - OFFW;
   localparam int LINEW = 8 * LINE_LENGTH;
   localparam int CNTW  = OFFW + 1;
   localparam int NNIB  = 2 * LINE_LENGTH;

   typedef enum logic {S_IDLE, S_FILL} state_t;

   state_t                r_state;
   logic [CNTW-1:0]       r_cnt;
   logic [LAW-1:0]        r_fill_line;
   logic                  r_fill_way;
   logic [NWAYS-1:0]      r_valid [NSETS];
   logic [NSETS-1:0]      r_lru;
   logic [LINEW-1:0]      r_data  [NWAYS][NSETS];
   logic [TAGW-1:0]       r_tags  [NWAYS][NSETS];

   logic [LAW-1:0]        w_line_addr;
   logic [IDXW-1:0]       w_idx;
   logic [TAGW-1:0]       w_ptag;
   logic [OFFW-1:0]       w_boff;
   logic [IDXW-1:0]       w_fset;
   logic [TAGW-1:0]       w_ftag;
   logic                  w_hit;
   logic                  w_hit_way;
   logic                  w_victim;
   logic [LINEW-1:0]      w_rline;
   logic [RV-1:0]         w_mask;
   logic                  w_start;
   logic                  w_step;
   logic                  w_last;
   logic                  w_wr_en;
   logic                  w_wr_way;
   logic [IDXW-1:0]       w_wr_set;
   logic [CNTW-1:0]       w_wr_nib;

   assign w_line_addr = paddr[PA-1:OFFW];
   assign w_idx       = paddr[OFFW+IDXW-1:OFFW];
   assign w_ptag      = paddr[PA-1:OFFW+IDXW];
   assign w_boff      = OFFW'({paddr, 1'b0});
   assign w_fset      = r_fill_line[IDXW-1:0];
   assign w_ftag      = r_fill_line[LAW-1:IDXW];

   always_comb begin
      w_hit     = 1'b0;
      w_hit_way = 1'b0;
      for (int w = 0; w < NWAYS; w++) begin
         if (r_valid[w_idx][w] && (r_tags[w][w_idx] == w_ptag)) begin
            w_hit     = 1'b1;
            w_hit_way = 1'(w);
         end
      end
   end

   // Lowest-numbered invalid way wins; otherwise the LRU bit picks the victim.
   always_comb begin
      w_victim = (NWAYS == 1) ? 1'b0 : r_lru[w_idx];
      for (int w = NWAYS - 1; w >= 0; w--) begin
         if (!r_valid[w_idx][w]) w_victim = 1'(w);
      end
   end

   assign w_rline = r_data[w_hit_way][w_idx];
   assign w_mask  = (RV == 32 && paddr[1]) ? RV'(16'hFFFF) : {RV{1'b1}};
   assign rdata   = RV'(w_rline >> {w_boff, 3'b000}) & w_mask;

   assign hit  = w_hit;
   assign pull = (r_state == S_FILL) ? 1'b1 : !w_hit;
   assign tag  = (r_state == S_FILL) ? r_fill_line : w_line_addr;

   assign w_start  = (r_state == S_IDLE) && !w_hit && wstrobe_d;
   assign w_step   = (r_state == S_FILL) && wstrobe_d;
   assign w_last   = w_step && (r_cnt == CNTW'(NNIB - 1));
   assign w_wr_en  = (w_start || w_step) && !reset && !flush_all;
   assign w_wr_way = (r_state == S_FILL) ? r_fill_way : w_victim;
   assign w_wr_set = (r_state == S_FILL) ? w_fset : w_idx;
   // Nibble k sits at nibble position k^1: even k is the high half of its byte.
   assign w_wr_nib = ((r_state == S_FILL) ? r_cnt : '0) ^ CNTW'(1);

   always_ff @(posedge clk) begin
      if (w_wr_en) r_data[w_wr_way][w_wr_set][{w_wr_nib, 2'b00} +: 4] <= dread;
      if (w_wr_en && w_last) r_tags[r_fill_way][w_fset] <= w_ftag;
   end

   always_ff @(posedge clk) begin
      if (reset || flush_all) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_valid <= '{default: '0};
         r_lru   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_hit) begin
                  r_lru[w_idx] <= ~w_hit_way;
               end else if (wstrobe_d) begin
                  r_fill_line               <= w_line_addr;
                  r_fill_way                <= w_victim;
                  r_valid[w_idx][w_victim]  <= 1'b0;
                  r_cnt                     <= CNTW'(1);
                  r_state                   <= S_FILL;
               end
            end
            S_FILL: begin
               if (w_last) begin
                  r_valid[w_fset][r_fill_way] <= 1'b1;
                  r_lru[w_fset]               <= ~r_fill_way;
                  r_cnt                       <= '0;
                  r_state                     <= S_IDLE;
               end else if (w_step) begin
                  r_cnt <= r_cnt + CNTW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: a default 2-way/16-bit instance and a
// 1-way/32-bit/8-byte-line instance, each checked against hand-computed values.
module tb_icache_assoc;

   localparam int PA = 22;

   logic          clk = 1'b0;
   logic          reset;
   logic [PA-1:1] paddr;
   logic [3:0]    dread;
   logic          wstrobe_d;
   logic          flush_all;
   logic          hit;
   logic          pull;
   logic [PA-1:2] tag;
   logic [15:0]   rdata;

   logic [PA-1:1] paddr_b;
   logic [3:0]    dread_b;
   logic          wstrobe_b;
   logic          flush_b;
   logic          hit_b;
   logic          pull_b;
   logic [PA-1:3] tag_b;
   logic [31:0]   rdata_b;

   int n_err = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   icache_assoc #(.LINE_LENGTH(4), .NSETS(4), .NWAYS(2), .RV(16), .PA(PA)) u_dut (
      .clk(clk), .reset(reset), .paddr(paddr), .dread(dread), .wstrobe_d(wstrobe_d),
      .flush_all(flush_all), .hit(hit), .pull(pull), .tag(tag), .rdata(rdata));

   icache_assoc #(.LINE_LENGTH(8), .NSETS(4), .NWAYS(1), .RV(32), .PA(PA)) u_dut_b (
      .clk(clk), .reset(reset), .paddr(paddr_b), .dread(dread_b), .wstrobe_d(wstrobe_b),
      .flush_all(flush_b), .hit(hit_b), .pull(pull_b), .tag(tag_b), .rdata(rdata_b));

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic go(input logic [PA-1:0] a);
      paddr = a[PA-1:1];
      #1;
   endtask

   task automatic stb(input logic [3:0] d);
      wstrobe_d = 1'b1;
      dread     = d;
      cyc();
      wstrobe_d = 1'b0;
   endtask

   task automatic fill(input logic [PA-1:0] a, input logic [31:0] nibs);
      go(a);
      for (int k = 0; k < 8; k++) stb(nibs[31-4*k -: 4]);
   endtask

   // Access one address for a full cycle (so a hit also refreshes LRU).
   task automatic look(input string nm, input logic [PA-1:0] a, input logic h, input logic [15:0] d);
      go(a);
      chk({nm, ".hit"}, 32'(hit), 32'(h));
      chk({nm, ".pull"}, 32'(pull), 32'(!h));
      if (h) chk({nm, ".rdata"}, 32'(rdata), 32'(d));
      cyc();
   endtask

   task automatic go_b(input logic [PA-1:0] a);
      paddr_b = a[PA-1:1];
      #1;
   endtask

   task automatic fill_b(input logic [PA-1:0] a, input logic [63:0] nibs);
      go_b(a);
      for (int k = 0; k < 16; k++) begin
         wstrobe_b = 1'b1;
         dread_b   = nibs[63-4*k -: 4];
         cyc();
         wstrobe_b = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1; wstrobe_d = 1'b0; dread = '0; flush_all = 1'b0;
      wstrobe_b = 1'b0; dread_b = '0; flush_b = 1'b0;
      paddr = 21'(22'h100 >> 1);
      paddr_b = 21'(22'h040 >> 1);
      cyc(); cyc();
      reset = 1'b0;

      // Reset state
      go(22'h100);
      chk("rst.hit", 32'(hit), 32'h0);
      chk("rst.pull", 32'(pull), 32'h1);
      chk("rst.tag", 32'(tag), 32'h40);

      // Basic fill of A
      fill(22'h100, 32'h12345678);
      go(22'h100);
      chk("a.hit_next", 32'(hit), 32'h1);
      look("a0", 22'h100, 1'b1, 16'h3412);
      look("a2", 22'h102, 1'b1, 16'h7856);

      // B into set 0, way 1; touch A; C then evicts B
      fill(22'h200, 32'hABCDEF01);
      look("b0", 22'h200, 1'b1, 16'hCDAB);
      look("a_touch", 22'h100, 1'b1, 16'h3412);
      go(22'h300);
      stb(4'h2);
      go(22'h100);
      chk("fill.other_way_hit", 32'(hit), 32'h1);
      chk("fill.other_way_rdata", 32'(rdata), 32'h3412);
      chk("fill.pull", 32'(pull), 32'h1);
      chk("fill.tag_latched", 32'(tag), 32'hC0);
      go(22'h300);
      for (int k = 3; k <= 8; k++) stb(4'(k));
      chk("fill.victim_no_hit", 32'(hit), 32'h0);
      stb(4'h9);
      go(22'h300);
      chk("c.hit_next", 32'(hit), 32'h1);
      look("c0", 22'h300, 1'b1, 16'h4523);
      look("c2", 22'h302, 1'b1, 16'h8967);
      look("a_kept", 22'h100, 1'b1, 16'h3412);
      look("b_evicted", 22'h200, 1'b0, 16'h0);
      go(22'h200);
      chk("b.tag", 32'(tag), 32'h80);

      // Gapped strobes with paddr wandering; fill of set 1 must follow the latched line
      go(22'h104);
      for (int k = 1; k <= 8; k++) begin
         stb(4'(k));
         go(22'h3F0 ^ 22'(k << 4));
         cyc();
      end
      look("gap0", 22'h104, 1'b1, 16'h3412);
      look("gap2", 22'h106, 1'b1, 16'h7856);

      // Flush on the last nibble wins; a later fill still works
      go(22'h108);
      for (int k = 0; k < 7; k++) stb(4'(8 - k));
      flush_all = 1'b1;
      stb(4'h1);
      flush_all = 1'b0;
      go(22'h108);
      chk("flush.hit", 32'(hit), 32'h0);
      chk("flush.pull", 32'(pull), 32'h1);
      chk("flush.tag", 32'(tag), 32'h42);
      look("flush.a_gone", 22'h100, 1'b0, 16'h0);
      fill(22'h108, 32'h87654321);
      look("e0", 22'h108, 1'b1, 16'h6587);
      look("e2", 22'h10A, 1'b1, 16'h2143);

      // Strobes while hitting in idle are ignored
      go(22'h108);
      stb(4'hF);
      stb(4'hF);
      look("ign.e0", 22'h108, 1'b1, 16'h6587);
      go(22'h10C);
      chk("ign.tag", 32'(tag), 32'h43);

      // Reset mid-fill discards the fill and all valid lines
      stb(4'h1); stb(4'h2); stb(4'h3);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      go(22'h200);
      chk("rst2.hit", 32'(hit), 32'h0);
      chk("rst2.pull", 32'(pull), 32'h1);
      chk("rst2.tag", 32'(tag), 32'h80);
      look("rst2.e_gone", 22'h108, 1'b0, 16'h0);

      // 32-bit, direct-mapped, 8-byte line instance
      go_b(22'h040);
      chk("b32.miss", 32'(hit_b), 32'h0);
      chk("b32.pull", 32'(pull_b), 32'h1);
      chk("b32.tag", 32'(tag_b), 32'h8);
      fill_b(22'h040, 64'h0123456789ABCDEF);
      go_b(22'h040);
      chk("b32.hit", 32'(hit_b), 32'h1);
      chk("b32.w0", rdata_b, 32'h67452301);
      go_b(22'h044);
      chk("b32.w1", rdata_b, 32'hEFCDAB89);
      go_b(22'h042);
      chk("b32.h1", rdata_b, 32'h00006745);
      go_b(22'h046);
      chk("b32.h3", rdata_b, 32'h0000EFCD);
      fill_b(22'h060, 64'h5555555555555555);
      go_b(22'h060);
      chk("b32.repl", rdata_b, 32'h55555555);
      go_b(22'h040);
      chk("b32.old_gone", 32'(hit_b), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
